ary_mul: RTL and testbench



---
 rtl/ary_mul.sv | 40 ++++
 tb/tb_ary_mul.sv | 87 ++++++++
 2 files changed

// File: rtl/ary_mul.sv
// ary_mul: unsigned WIDTH x WIDTH array multiplier with a registered 2*WIDTH product
module ary_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] out
);
  logic [2*WIDTH-1:0] p;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   nxt;
  logic               c, x, y;
  // Each row ripples pp[i] into the previous row's upper bits; the row LSB retires as product bit i.
  always_comb begin
    acc = {1'b0, a & {WIDTH{b[0]}}};
    nxt = '0;
    c = 1'b0;
    x = 1'b0;
    y = 1'b0;
    p = '0;
    p[0] = acc[0];
    for (int i = 1; i < WIDTH; i++) begin
      c = 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        x = acc[j+1];
        y = a[j] & b[i];
        nxt[j] = x ^ y ^ c;
        c = (x & y) | (c & (x ^ y));
      end
      acc = {c, nxt};
      p[i] = acc[0];
    end
    p[2*WIDTH-1:WIDTH] = acc[WIDTH:1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out <= '0;
    else out <= p;
endmodule

// File: tb/tb_ary_mul.sv
// tb_ary_mul: self-checking bench for ary_mul (corner table, sweep, random, reset sequences)
module tb_ary_mul;
  typedef struct {
    string      n;
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] p;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [15:0] out;
  logic [15:0] held = '0;
  int          errs = 0;
  int          checks = 0;
  vec_t        tbl[12];
  always #5 clk = ~clk;
  ary_mul #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out));
  task automatic chk(input string n, input logic [15:0] exp);
    checks++;
    if (out !== exp) begin
      errs++;
      $display("FAIL %s: out=%0d expected=%0d", n, out, exp);
    end
  endtask
  // Drive operands mid-cycle, confirm out has not moved, then check the product after the edge.
  task automatic apply(input string n, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
    a = x;
    b = y;
    #1 chk({n, " hold"}, held);
    @(posedge clk);
    #1 chk(n, exp);
    held = exp;
  endtask
  initial begin
    tbl[0]  = '{"zero x zero",   8'd0,   8'd0,   16'd0};
    tbl[1]  = '{"max x zero",    8'd255, 8'd0,   16'd0};
    tbl[2]  = '{"one x max",     8'd1,   8'd255, 16'd255};
    tbl[3]  = '{"max x max",     8'd255, 8'd255, 16'hFE01};
    tbl[4]  = '{"128 x 128",     8'd128, 8'd128, 16'd16384};
    tbl[5]  = '{"carry ff*01",   8'hFF,  8'h01,  16'd255};
    tbl[6]  = '{"carry ff*03",   8'hFF,  8'h03,  16'd765};
    tbl[7]  = '{"carry ff*7f",   8'hFF,  8'h7F,  16'd32385};
    tbl[8]  = '{"carry ff*80",   8'hFF,  8'h80,  16'd32640};
    tbl[9]  = '{"carry ff*fe",   8'hFF,  8'hFE,  16'd64770};
    tbl[10] = '{"200 x 100",     8'd200, 8'd100, 16'd20000};
    tbl[11] = '{"170 x 85",      8'd170, 8'd85,  16'd14450};
    a = 8'd200;
    b = 8'd100;
    repeat (3) @(posedge clk);
    #1 chk("reset hold", 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("reset release", 16'd20000);
    #3 rst_n = 1'b0;
    #1 chk("async reset", 16'd0);
    held = '0;
    @(posedge clk);
    #1 chk("reset held at edge", 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) apply(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].p);
    for (int k = 0; k < 8; k++)
      for (int m = 0; m < 8; m++)
        apply("bit isolation", 8'(1 << k), 8'(1 << m), 16'(1 << (k + m)));
    for (int i = 0; i < 8; i++) begin
      apply("b2b max", 8'd255, 8'd255, 16'd65025);
      apply("b2b zero", 8'd0, 8'd0, 16'd0);
    end
    for (int i = 0; i < 300; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = 8'($urandom);
      apply("random", x, y, 16'(x) * 16'(y));
    end
    for (int x = 0; x < 256; x++)
      for (int y = 0; y < 255; y++)
        apply("sweep", 8'(x), 8'(y), 16'(x * y));
    #3 rst_n = 1'b0;
    #1 chk("mid-stream reset", 16'd0);
    held = '0;
    #2 rst_n = 1'b1;
    apply("post reset", 8'd13, 8'd11, 16'd143);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
